// File: rtl/rv_counter_bank_pkg.sv
// Shared types for the rv_counter_bank counter bank.
// Mode encoding 2'b11 is reserved and behaves like WRAP.
package rv_counter_bank_pkg;

    typedef enum logic [1:0] {
        RV_COUNT_WRAP     = 2'b00,
        RV_COUNT_SATURATE = 2'b01,
        RV_COUNT_ONESHOT  = 2'b10
    } rv_counter_mode_t;

    // True when the mode keeps the count in place at the terminal value.
    function automatic logic holds_at_terminal(input logic [1:0] mode);
        return (mode == RV_COUNT_SATURATE) || (mode == RV_COUNT_ONESHOT);
    endfunction

endpackage

// File: rtl/rv_counter_channel.sv
// One up/down counter with wrap/saturate/one-shot terminal handling.
// Priority per cycle: clear > load_enable > enable > hold.
module rv_counter_channel
    import rv_counter_bank_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             up,
    input  logic             load_enable,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] value,
    output logic             complete,
    output logic             done
);

    logic [WIDTH-1:0] value_q, value_d;
    logic             done_q, done_d;
    logic             terminal;

    always_comb begin
        terminal = up ? (value_q == max) : (value_q == '0);
        // rst gates the strobe so nothing fires while the bank is held in reset.
        complete = rst & enable & terminal & ~done_q & ~clear & ~load_enable;
    end

    always_comb begin
        value_d = value_q;
        done_d  = done_q;
        if (clear) begin
            value_d = '0;
            done_d  = 1'b0;
        end else if (load_enable) begin
            value_d = load_value;
            done_d  = 1'b0;
        end else if (enable && !done_q) begin
            if (!terminal) begin
                value_d = up ? value_q + WIDTH'(1) : value_q - WIDTH'(1);
            end else if (holds_at_terminal(mode)) begin
                done_d = (mode == RV_COUNT_ONESHOT);
            end else begin
                value_d = up ? '0 : max;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= RESET_VALUE;
            done_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign value = value_q;
    assign done  = done_q;

endmodule

// File: rtl/rv_counter_bank.sv
// Bank of CHANNELS independent counters with flat packed per-channel controls.
// any_complete is the OR of the per-channel terminal strobes.
module rv_counter_bank
    import rv_counter_bank_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      CHANNELS    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       up,
    input  logic [CHANNELS-1:0]       load_enable,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS*WIDTH-1:0] max,
    input  logic [CHANNELS*2-1:0]     mode,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       complete,
    output logic [CHANNELS-1:0]       done,
    output logic                      any_complete
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        rv_counter_channel #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable[i]),
            .clear       (clear[i]),
            .up          (up[i]),
            .load_enable (load_enable[i]),
            .load_value  (load_value[i*WIDTH +: WIDTH]),
            .max         (max[i*WIDTH +: WIDTH]),
            .mode        (mode[i*2 +: 2]),
            .value       (value[i*WIDTH +: WIDTH]),
            .complete    (complete[i]),
            .done        (done[i])
        );
    end

    assign any_complete = |complete;

endmodule

// File: tb/tb_rv_counter_bank.sv
// Directed bench for rv_counter_bank: per-cycle comparison against a behavioural
// model plus literal expectations taken from the intended behaviour.
module tb_rv_counter_bank;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int RV = 8'h05;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [CH-1:0]   enable = '0, clear = '0, up = '0, load_enable = '0;
    logic [CH*W-1:0] load_value = '0, max = '0;
    logic [CH*2-1:0] mode = '0;
    logic [CH*W-1:0] value;
    logic [CH-1:0]   complete, done;
    logic            any_complete;

    int checks = 0;
    int fails  = 0;
    bit model_on = 1'b0;

    // Model state: current count and sticky flag per channel, plus next state.
    int mv[CH];
    bit md[CH];
    int nv[CH];
    bit nd[CH];

    rv_counter_bank #(
        .WIDTH       (W),
        .CHANNELS    (CH),
        .RESET_VALUE (8'h05)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .up           (up),
        .load_enable  (load_enable),
        .load_value   (load_value),
        .max          (max),
        .mode         (mode),
        .value        (value),
        .complete     (complete),
        .done         (done),
        .any_complete (any_complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int mx, input logic [1:0] md_in, input bit dir);
        max[c*W +: W]  = W'(mx);
        mode[c*2 +: 2] = md_in;
        up[c]          = dir;
    endtask

    function automatic bit model_term(input int c);
        int m;
        m = int'(max[c*W +: W]);
        return up[c] ? (mv[c] == m) : (mv[c] == 0);
    endfunction

    // Compare on the falling edge, then work out what the next rising edge must produce.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                logic [CH*W-1:0] ev;
                logic [CH-1:0]   ec, ed;
                for (int i = 0; i < CH; i++) begin
                    ev[i*W +: W] = W'(mv[i]);
                    ed[i] = md[i];
                    ec[i] = rst && enable[i] && model_term(i) && !md[i] && !clear[i]
                            && !load_enable[i];
                end
                chk("value", 32'(value), 32'(ev));
                chk("done", 32'(done), 32'(ed));
                chk("complete", 32'(complete), 32'(ec));
                chk("any_complete", 32'(any_complete), 32'(|ec));
            end
            for (int i = 0; i < CH; i++) begin
                int m;
                m     = int'(max[i*W +: W]);
                nv[i] = mv[i];
                nd[i] = md[i];
                if (clear[i]) begin
                    nv[i] = 0;
                    nd[i] = 1'b0;
                end else if (load_enable[i]) begin
                    nv[i] = int'(load_value[i*W +: W]);
                    nd[i] = 1'b0;
                end else if (enable[i] && !md[i]) begin
                    if (!model_term(i))       nv[i] = up[i] ? (mv[i] + 1) % 256 : (mv[i] + 255) % 256;
                    else if (mode[i*2 +: 2] == 2'b01) nv[i] = mv[i];
                    else if (mode[i*2 +: 2] == 2'b10) nd[i] = 1'b1;
                    else                      nv[i] = up[i] ? 0 : m;
                end
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < CH; i++) begin
            if (!rst) begin
                mv[i] <= RV;
                md[i] <= 1'b0;
            end else begin
                mv[i] <= nv[i];
                md[i] <= nd[i];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst = 1'b1;
        model_on = 1'b1;
        #1;
        chk("reset_value0", 32'(value[0 +: W]), 32'h05);
        chk("reset_done", 32'(done), 32'h0);

        // Ch0 wrap up, max 3.
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        set_ch(0, 3, 2'b00, 1'b1);
        enable[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("wrap_value", 32'(value[0 +: W]), 32'(k % 4));
            chk("wrap_complete", 32'(complete[0]), 32'(k % 4 == 3));
            chk("wrap_any", 32'(any_complete), 32'(k % 4 == 3));
            tick();
        end
        enable[0] = 1'b0;

        // Ch1 saturate down from 2.
        set_ch(1, 0, 2'b01, 1'b0);
        load_value[1*W +: W] = 8'd2;
        load_enable[1] = 1'b1;
        tick();
        load_enable[1] = 1'b0;
        enable[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("sat_value", 32'(value[1*W +: W]), 32'((k < 2) ? 2 - k : 0));
            chk("sat_complete", 32'(complete[1]), 32'(k >= 2));
            tick();
        end
        enable[1] = 1'b0;

        // Ch2 one-shot up, max 2.
        clear[2] = 1'b1;
        tick();
        clear[2] = 1'b0;
        set_ch(2, 2, 2'b10, 1'b1);
        enable[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("os_value", 32'(value[2*W +: W]), 32'((k < 2) ? k : 2));
            chk("os_complete", 32'(complete[2]), 32'(k == 2));
            chk("os_done", 32'(done[2]), 32'(k >= 3));
            tick();
        end
        enable[2] = 1'b0;
        clear[2] = 1'b1;
        tick();
        clear[2] = 1'b0;
        #1;
        chk("os_clear_value", 32'(value[2*W +: W]), 32'h0);
        chk("os_clear_done", 32'(done[2]), 32'h0);

        // Ch3 priority: clear beats load beats enable.
        set_ch(3, 0, 2'b00, 1'b1);
        load_value[3*W +: W] = 8'h7F;
        clear[3] = 1'b1;
        load_enable[3] = 1'b1;
        enable[3] = 1'b1;
        #1;
        chk("prio_complete", 32'(complete[3]), 32'h0);
        tick();
        chk("prio_value", 32'(value[3*W +: W]), 32'h0);
        clear[3] = 1'b0;
        enable[3] = 1'b0;
        tick();
        load_enable[3] = 1'b0;
        chk("load_value", 32'(value[3*W +: W]), 32'h7F);

        // Independence and rollover: ch0 up past 0xFF, ch1 down wrap to max.
        set_ch(0, 8'h10, 2'b00, 1'b1);
        set_ch(1, 8'h0A, 2'b00, 1'b0);
        load_value[0 +: W] = 8'hFE;
        load_value[1*W +: W] = 8'h00;
        load_enable[1:0] = 2'b11;
        tick();
        load_enable[1:0] = 2'b00;
        enable[1:0] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("roll_value0", 32'(value[0 +: W]), 32'((254 + k) % 256));
            chk("roll_value1", 32'(value[1*W +: W]), 32'((k == 0) ? 0 : 11 - k));
            chk("roll_complete", 32'(complete[1:0]), 32'((k == 0) ? 2'b10 : 2'b00));
            tick();
        end
        enable[1] = 1'b0;

        // Asynchronous reset mid-count with ch2 done set and ch2 sitting at terminal.
        set_ch(2, 0, 2'b10, 1'b1);
        enable[2] = 1'b1;
        tick();
        #1;
        chk("pre_reset_done", 32'(done[2]), 32'h1);
        max[2*W +: W] = 8'h05;
        #1;
        rst = 1'b0;
        #1;
        chk("async_value0", 32'(value[0 +: W]), 32'h05);
        chk("async_done", 32'(done), 32'h0);
        chk("async_complete", 32'(complete), 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("post_reset_complete2", 32'(complete[2]), 32'h1);
        tick();
        chk("post_reset_done2", 32'(done[2]), 32'h1);
        chk("post_reset_value2", 32'(value[2*W +: W]), 32'h05);
        enable = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
